branch_ctrl_seq: RTL and testbench
==================================

// Module: branch_ctrl_seq
// PURPOSE
//  Sequencer around the branch-decision datapath. Accepts a branch op from decode and
//  stalls fetch while the ALU flags for the compare settle. It then resolves the branch,
//  and on a taken branch drives the PC select and pipeline flush for a fixed number of
//  cycles. It also keeps saturating branch statistics for debug readback.
// PARAMETERS
//  FLAG_LAT      2   cycles spent in WAIT for in-flight compare to write flags (>=1)
//  FLUSH_CYCLES  2   cycles flush is held after a taken branch (>=1)
//  CNT_W         16  width of statistics counters
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  br_valid       in   1      decode presents an instruction this cycle (1-cycle pulse)
//  opcode         in   5      opcode; BEQ=10011 BLT=10100 BGT=10101 BNE=10110
//  flags_vld      in   1      ALU writes flags this cycle
//  flags          in   2      [1]=Z (zero), [0]=N (negative)
//  stall_fetch    out  1      hold IF/ID; high in WAIT, EVAL, FLUSH
//  pc_branch_sel  out  1      select branch target for PC; first FLUSH cycle only
//  flush          out  1      squash IF/ID contents; high in every FLUSH cycle
//  busy           out  1      state != IDLE
//  br_drop        out  1      1-cycle pulse: branch op arrived while busy and was ignored
//  br_total_cnt   out  CNT_W  resolved branches, saturating
//  br_taken_cnt   out  CNT_W  taken branches, saturating
// BEHAVIOUR
//  Reset (async, any state)
//  - state=IDLE, flag reg=00, counters=0, all 1-bit outputs 0.
//  - Abandons any in-progress branch; no flush issued.
//  Outputs
//  - All outputs are decoded from registered state/regs only (Moore); none depend
//    combinationally on inputs.
//  Flag register
//  - Loaded from flags on any cycle with flags_vld=1, regardless of state.
//  FSM
//  - IDLE : br_valid & opcode in {BEQ,BLT,BGT,BNE} -> latch opcode, wait ctr=FLAG_LAT-1, go WAIT.
//           br_valid with other opcodes is ignored (no state change, no drop).
//  - WAIT : ctr decrements each cycle; at ctr==0 go EVAL. WAIT lasts exactly FLAG_LAT cycles.
//  - EVAL : one cycle. Decision uses eff_flags = flags_vld ? flags : flag reg (same-cycle bypass).
//           Taken rules:
//             BEQ  Z==1
//             BNE  Z==0
//             BLT  N==1
//             BGT  N==0
//           total_cnt+=1; if taken, taken_cnt+=1 (both saturate at all-ones, no wrap).
//           Taken -> FLUSH with flush ctr=FLUSH_CYCLES-1. Not taken -> IDLE.
//  - FLUSH: pc_branch_sel=1 on entry cycle only; flush=1 every cycle; ctr==0 -> IDLE.
//  Latency
//  - br_valid sampled on edge E0: WAIT for cycles 1..FLAG_LAT, EVAL at cycle FLAG_LAT+1.
//  - Taken: FLUSH for the next FLUSH_CYCLES cycles.
//  - stall_fetch drops the cycle after EVAL (not taken) or after the last FLUSH cycle (taken).
//  Boundary conditions
//  - br_valid with a branch opcode while state!=IDLE: ignored; br_drop pulses the next cycle.
//  - Branch accepted in the same cycle the FSM returns to IDLE: not possible. IDLE is always
//    at least one cycle, so decode reissues after stall_fetch falls.
//  - flags_vld and EVAL in the same cycle: the new flags decide, and the flag reg also loads.
//  - Counter saturation: held at all-ones; the other counter is unaffected.
// TESTING
//  Params FLAG_LAT=2, FLUSH_CYCLES=2, CNT_W=4.
//  1. Reset, then BEQ pulse, flags_vld w/ flags=10 in cycle 1
//     -> stall cycles 1-5; pc_branch_sel cycle 4 only; flush cycles 4-5; idle cycle 6;
//        total=1, taken=1.
//  2. BNE with flag reg=11 -> EVAL cycle 3 not taken; no flush/pc_sel; stall 1-3; taken unchanged.
//  3. BLT with flag reg=00, flags_vld w/ flags=01 in EVAL cycle -> taken (bypass); flush cycles 4-5.
//  4. BGT sweep flags 00,10,01,11 -> taken,taken,not,not; then 5th branch op during WAIT
//     -> br_drop pulse, no extra resolve.
//  5. 20 taken BEQs -> both counters stick at 4'hF.
//     Non-branch opcode 00001 with br_valid -> no state change.
//  6. Assert rst_n low mid-FLUSH -> all outputs 0 immediately, counters 0; next BEQ runs the
//     full sequence.

Source files
------------

// File: rtl/branch_ctrl_seq_if.sv
// Decode/ALU-facing signal bundle for the branch sequencer.
// The master side is decode plus the ALU flag writer; the slave side is branch_ctrl_seq.
interface branch_ctrl_seq_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic [4:0]       opcode;
  logic             flags_vld;
  logic [1:0]       flags;
  logic             stall_fetch;
  logic             pc_branch_sel;
  logic             flush;
  logic             busy;
  logic             br_drop;
  logic [CNT_W-1:0] br_total_cnt;
  logic [CNT_W-1:0] br_taken_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output br_valid, opcode, flags_vld, flags,
    input  stall_fetch, pc_branch_sel, flush, busy, br_drop,
    input  br_total_cnt, br_taken_cnt, state_dbg
  );

  modport slave (
    input  br_valid, opcode, flags_vld, flags,
    output stall_fetch, pc_branch_sel, flush, busy, br_drop,
    output br_total_cnt, br_taken_cnt, state_dbg
  );
endinterface

// File: rtl/branch_ctrl_seq.sv
// Branch sequencer: waits for compare flags, resolves the branch, drives PC select
// and pipeline flush on taken branches, and keeps saturating branch statistics.
module branch_ctrl_seq #(
  parameter int FLAG_LAT     = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst_n,
  branch_ctrl_seq_if.slave bus
);
  localparam int MAX_C = (FLAG_LAT > FLUSH_CYCLES) ? FLAG_LAT : FLUSH_CYCLES;
  localparam int CTR_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BLT = 5'b10100;
  localparam logic [4:0] OP_BGT = 5'b10101;
  localparam logic [4:0] OP_BNE = 5'b10110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EVAL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [4:0]       op_q, op_d;
  logic [1:0]       flag_q, flag_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [CNT_W-1:0] tk_q, tk_d;
  logic             drop_q, drop_d;
  logic             is_br;
  logic [1:0]       eff_flags;
  logic             taken;

  // Handshake: br_valid is a one-cycle pulse with no ready. A branch op is taken only
  // in IDLE; one arriving in any other state is discarded and reported on br_drop.
  assign is_br = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BLT) ||
                 (bus.opcode == OP_BGT) || (bus.opcode == OP_BNE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      op_q    <= '0;
      flag_q  <= '0;
      tot_q   <= '0;
      tk_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
      tot_q   <= tot_d;
      tk_q    <= tk_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    op_d      = op_q;
    tot_d     = tot_q;
    tk_d      = tk_q;
    taken     = 1'b0;
    flag_d    = bus.flags_vld ? bus.flags : flag_q;
    eff_flags = bus.flags_vld ? bus.flags : flag_q;
    drop_d    = bus.br_valid && is_br && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.br_valid && is_br) begin
          op_d    = bus.opcode;
          ctr_d   = CTR_W'(FLAG_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ctr_q == '0) state_d = S_EVAL;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      S_EVAL: begin
        // eff_flags[1] is Z, eff_flags[0] is N; a flag write this cycle wins.
        case (op_q)
          OP_BEQ:  taken = eff_flags[1];
          OP_BNE:  taken = !eff_flags[1];
          OP_BLT:  taken = eff_flags[0];
          OP_BGT:  taken = !eff_flags[0];
          default: taken = 1'b0;
        endcase
        if (tot_q != '1)          tot_d = tot_q + CNT_W'(1);
        if (taken && tk_q != '1)  tk_d  = tk_q + CNT_W'(1);
        if (taken) begin
          ctr_d   = CTR_W'(FLUSH_CYCLES - 1);
          state_d = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (ctr_q == '0) state_d = S_IDLE;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stall_fetch   = (state_q != S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.flush         = (state_q == S_FLUSH);
  assign bus.pc_branch_sel = (state_q == S_FLUSH) && (ctr_q == CTR_W'(FLUSH_CYCLES - 1));
  assign bus.br_drop       = drop_q;
  assign bus.br_total_cnt  = tot_q;
  assign bus.br_taken_cnt  = tk_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Table-driven bench for branch_ctrl_seq with FLAG_LAT=2, FLUSH_CYCLES=2, CNT_W=4.
module tb_branch_ctrl_seq;
  localparam int CNT_W = 4;
  localparam int EW    = 5 + 2 * CNT_W;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  typedef struct {
    bit          bv;
    logic [4:0]  op;
    bit          fv;
    logic [1:0]  fl;
    logic [EW-1:0] exp;  // {stall, pc_sel, flush, busy, drop, total, taken}
  } vec_t;

  logic clk;
  logic rst_n;

  branch_ctrl_seq_if #(.CNT_W(CNT_W)) bus ();

  branch_ctrl_seq #(
    .FLAG_LAT    (2),
    .FLUSH_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t             tbl[$];
  logic [EW-1:0]    exp_q[$];
  int               n_vec;
  int               n_err;
  logic [CNT_W-1:0] tot_m;
  logic [CNT_W-1:0] tk_m;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic vec_t mk(input bit bv, input logic [4:0] op, input bit fv,
                              input logic [1:0] fl, input bit st, input bit pc,
                              input bit fs, input bit by, input bit dr);
    vec_t r;
    r.bv  = bv;
    r.op  = op;
    r.fv  = fv;
    r.fl  = fl;
    r.exp = {st, pc, fs, by, dr, tot_m, tk_m};
    return r;
  endfunction

  // One full branch: issue cycle, two WAIT cycles, EVAL, then FLUSH x2 if taken, then idle.
  task automatic add_branch(input logic [4:0] op, input int fv_cyc,
                            input logic [1:0] fl, input bit taken);
    bit fvv;
    for (int c = 0; c < 4; c++) begin
      fvv = (c == fv_cyc);
      tbl.push_back(mk(c == 0, (c == 0) ? op : 5'd0, fvv, fvv ? fl : 2'b00,
                       c != 0, 1'b0, 1'b0, c != 0, 1'b0));
    end
    tot_m = sat(tot_m);
    if (taken) begin
      tk_m = sat(tk_m);
      tbl.push_back(mk(0, 5'd0, 0, 2'b00, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 5'd0, 0, 2'b00, 1, 0, 1, 1, 0));
    end
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
  endtask

  // scoreboard compare
  task automatic compare(input string nm);
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    e   = exp_q.pop_front();
    got = {bus.stall_fetch, bus.pc_branch_sel, bus.flush, bus.busy, bus.br_drop,
           bus.br_total_cnt, bus.br_taken_cnt};
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: {stall,pc,flush,busy,drop,tot,tk} got %b_%h_%h want %b_%h_%h",
               nm, got[EW-1 -: 5], got[2*CNT_W-1 -: CNT_W], got[CNT_W-1:0],
               e[EW-1 -: 5], e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
    end
  endtask

  task automatic check_now(input string nm, input logic [EW-1:0] e);
    exp_q.push_back(e);
    compare(nm);
  endtask

  // driver
  task automatic apply_vec(input vec_t t, input string nm);
    @(posedge clk);
    #1;
    bus.br_valid  = t.bv;
    bus.opcode    = t.op;
    bus.flags_vld = t.fv;
    bus.flags     = t.fl;
    exp_q.push_back(t.exp);
    @(negedge clk);
    compare(nm);
  endtask

  task automatic run_tbl(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) apply_vec(tbl[i], $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tot_m = '0;
    tk_m  = '0;
    rst_n = 1'b0;
    bus.br_valid  = 1'b0;
    bus.opcode    = 5'd0;
    bus.flags_vld = 1'b0;
    bus.flags     = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset", '0);
    #1 rst_n = 1'b1;

    // 1: BEQ, flags 10 written in cycle 1 -> taken
    add_branch(BEQ, 1, 2'b10, 1);
    // 2: BNE with flag reg 11 -> not taken
    add_branch(BNE, 0, 2'b11, 0);
    // 3: flag reg 00, then BLT with 01 bypassed in EVAL -> taken
    tbl.push_back(mk(0, 5'd0, 1, 2'b00, 0, 0, 0, 0, 0));
    add_branch(BLT, 3, 2'b01, 1);
    // 4: BGT sweep
    add_branch(BGT, 0, 2'b00, 1);
    add_branch(BGT, 0, 2'b10, 1);
    add_branch(BGT, 0, 2'b01, 0);
    add_branch(BGT, 0, 2'b11, 0);
    // branch op arriving in WAIT: dropped, pulse next cycle, no extra resolve
    tbl.push_back(mk(1, BGT, 1, 2'b11, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, BEQ, 0, 2'b00, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 1, 0, 0, 1, 0));
    tot_m = sat(tot_m);
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
    // 5: saturation
    for (int k = 0; k < 20; k++) add_branch(BEQ, 0, 2'b10, 1);
    // non-branch opcode ignored
    tbl.push_back(mk(1, 5'b00001, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 0));
    run_tbl(0, tbl.size(), "tbl");

    // 6: reset asserted in the first FLUSH cycle
    tbl.delete();
    add_branch(BEQ, 0, 2'b10, 1);
    run_tbl(0, 5, "pre_rst");
    #2 rst_n = 1'b0;
    #1 check_now("rst_mid_flush", '0);
    @(posedge clk);
    @(negedge clk);
    check_now("rst_hold", '0);
    #1 rst_n = 1'b1;
    tot_m = '0;
    tk_m  = '0;
    tbl.delete();
    add_branch(BEQ, 0, 2'b10, 1);
    run_tbl(0, tbl.size(), "post_rst");

    bus.br_valid  = 1'b0;
    bus.flags_vld = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
